// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and state encodings shared by the execute unit
package alu_pkg;

    localparam int                          DATA_WIDTH_DEF = 32;
    localparam int                          SHAMT_W        = $clog2(DATA_WIDTH_DEF);
    localparam logic [DATA_WIDTH_DEF-1:0]   MIN_INT        = {1'b1, {(DATA_WIDTH_DEF-1){1'b0}}};

    typedef enum logic [4:0] {
        OP_AND    = 5'h00,
        OP_OR     = 5'h01,
        OP_ADD    = 5'h02,
        OP_XOR    = 5'h03,
        OP_SLL    = 5'h04,
        OP_SRL    = 5'h05,
        OP_SUB    = 5'h06,
        OP_SLT    = 5'h07,
        OP_EQ     = 5'h08,
        OP_SRA    = 5'h09,
        OP_NE     = 5'h0A,
        OP_BGE    = 5'h0B,
        OP_JAL    = 5'h0C,
        OP_MUL    = 5'h10,
        OP_MULH   = 5'h11,
        OP_MULHSU = 5'h12,
        OP_MULHU  = 5'h13,
        OP_DIV    = 5'h14,
        OP_DIVU   = 5'h15,
        OP_REM    = 5'h16,
        OP_REMU   = 5'h17
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_div_op(input op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative shift-add multiplier / restoring divider on magnitudes
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  op_e                   op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  step_en,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  last
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic [2*W-1:0] acc, acc_next, prod_fix;
    logic [W-1:0]   mcand, a_mag, b_mag, part;
    logic [W:0]     sum, rem_sh, diff;
    logic [CW-1:0]  count;
    logic           is_div, neg_res, sel_hi, a_neg, b_neg;

    always_comb begin
        a_neg = a[W-1] && (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        b_neg = b[W-1] && (op inside {OP_MULH, OP_DIV, OP_REM});
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            mcand   <= '0;
            count   <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            sel_hi  <= 1'b0;
        end else if (start) begin
            count  <= CW'(W);
            is_div <= is_div_op(op);
            if (is_div_op(op)) begin
                // quotient bits shift in at the bottom while the remainder grows in the top half
                acc     <= {{W{1'b0}}, a_mag};
                mcand   <= b_mag;
                neg_res <= (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
                sel_hi  <= op inside {OP_REM, OP_REMU};
            end else begin
                acc     <= {{W{1'b0}}, b_mag};
                mcand   <= a_mag;
                neg_res <= a_neg ^ b_neg;
                sel_hi  <= (op != OP_MUL);
            end
        end else if (step_en) begin
            acc   <= acc_next;
            count <= count - 1'b1;
        end
    end

    always_comb begin
        sum    = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mcand} : {(W+1){1'b0}});
        rem_sh = acc[2*W-1:W-1];
        diff   = rem_sh - {1'b0, mcand};
        if (is_div) begin
            acc_next = diff[W] ? {rem_sh[W-1:0], acc[W-2:0], 1'b0}
                               : {diff[W-1:0],   acc[W-2:0], 1'b1};
        end else begin
            acc_next = {sum, acc[W-1:1]};
        end
        // sign is applied to the value produced by this cycle's step so the final edge can register it
        prod_fix = neg_res ? -acc_next : acc_next;
        part     = sel_hi ? acc_next[2*W-1:W] : acc_next[W-1:0];
        if (is_div) begin
            result = neg_res ? -part : part;
        end else begin
            result = sel_hi ? prod_fix[2*W-1:W] : prod_fix[W-1:0];
        end
    end

    assign last = (count == CW'(1));

endmodule

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - multi-cycle EX unit: base ALU ops plus RV32M with valid/ready and flush
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     Flush,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     Busy
);

    localparam int                    SW      = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ONE     = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] ZERO    = '0;

    state_e                state, state_next;
    op_e                   op;
    logic                  accept, special, m_iter, start, step_en, last;
    logic                  div_by_zero, overflow;
    logic [SW-1:0]         shamt;
    logic [DATA_WIDTH-1:0] base_result, quick_result, iter_result;

    assign op       = op_e'(Operation);
    assign shamt    = SrcB[SW-1:0];
    assign InReady  = (state == IDLE) || ((state == DONE) && OutReady);
    assign accept   = InValid && InReady && !Flush;
    assign OutValid = (state == DONE);
    assign Busy     = (state != IDLE);
    assign start    = accept && m_iter;
    assign step_en  = (state == CALC) && !Flush;

    always_comb begin
        base_result = '0;
        case (op)
            OP_AND:  base_result = SrcA & SrcB;
            OP_OR:   base_result = SrcA | SrcB;
            OP_ADD:  base_result = SrcA + SrcB;
            OP_XOR:  base_result = SrcA ^ SrcB;
            OP_SLL:  base_result = SrcA << shamt;
            OP_SRL:  base_result = SrcA >> shamt;
            OP_SUB:  base_result = SrcA - SrcB;
            OP_SLT:  base_result = ($signed(SrcA) < $signed(SrcB)) ? ONE : ZERO;
            OP_EQ:   base_result = (SrcA == SrcB) ? ONE : ZERO;
            OP_SRA:  base_result = $signed(SrcA) >>> shamt;
            OP_NE:   base_result = (SrcA != SrcB) ? ONE : ZERO;
            OP_BGE:  base_result = ($signed(SrcA) >= $signed(SrcB)) ? ONE : ZERO;
            OP_JAL:  base_result = ONE;
            default: base_result = '0;
        endcase
    end

    assign div_by_zero = (SrcB == '0);
    assign overflow    = (SrcA == MIN_VAL) && (SrcB == '1);

    // M ops whose answer is known at accept skip the iterative datapath entirely
    always_comb begin
        special      = 1'b0;
        quick_result = base_result;
        if (Operation[4]) begin
            quick_result = '0;
            special      = Operation[3];
            case (op)
                OP_DIV: begin
                    if (div_by_zero) begin
                        special      = 1'b1;
                        quick_result = '1;
                    end else if (overflow) begin
                        special      = 1'b1;
                        quick_result = MIN_VAL;
                    end
                end
                OP_DIVU: begin
                    if (div_by_zero) begin
                        special      = 1'b1;
                        quick_result = '1;
                    end
                end
                OP_REM: begin
                    if (div_by_zero) begin
                        special      = 1'b1;
                        quick_result = SrcA;
                    end else if (overflow) begin
                        special      = 1'b1;
                        quick_result = '0;
                    end
                end
                OP_REMU: begin
                    if (div_by_zero) begin
                        special      = 1'b1;
                        quick_result = SrcA;
                    end
                end
                default: ;
            endcase
        end
        m_iter = Operation[4] && !special;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = m_iter ? CALC : DONE;
            CALC: if (last) state_next = DONE;
            DONE: if (OutReady) state_next = accept ? (m_iter ? CALC : DONE) : IDLE;
            default: state_next = IDLE;
        endcase
        if (Flush) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUResult <= '0;
        end else if (!Flush) begin
            if (accept && !m_iter) begin
                ALUResult <= quick_result;
            end else if (step_en && last) begin
                ALUResult <= iter_result;
            end
        end
    end

    muldiv_iter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_muldiv_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (SrcA),
        .b       (SrcB),
        .step_en (step_en),
        .result  (iter_result),
        .last    (last)
    );

endmodule
